// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-driven controller for an external W-bit ALU.
// Accepts one operation per command handshake, registers the ALU inputs,
// waits ALU_LAT extra cycles, captures y/carry and returns them on the
// result channel. An accumulator holds the last accepted result so
// operations can be chained without resending operand A.
//
// Handshakes: a transfer happens on a rising edge where both valid and
// ready are high. A producer holding valid keeps its payload stable until
// that edge; valid never depends on ready. cmd_ready is high only in IDLE,
// res_valid is high only in RESP.
module alu_op_sequencer #(
    parameter int W       = 8,
    parameter int ALU_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_use_acc,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_s,
    input  logic [W-1:0]     alu_y,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_y,
    output logic             res_carry,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic [W-1:0]     acc;
    logic             accept;
    logic             lat_done;
    logic             res_done;

    assign accept   = cmd_valid && cmd_ready;
    assign lat_done = (state == EXEC) && (lat_cnt == LAT_W'(ALU_LAT));
    assign res_done = res_valid && res_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the state-decoded outputs cmd_ready and busy.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (lat_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ALU operand registers: loaded only on accept, held through EXEC/RESP
    // so the ALU sees stable inputs until the next command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_s <= '0;
        end else if (accept) begin
            alu_a <= cmd_use_acc ? acc : cmd_a;
            alu_b <= cmd_b;
            alu_s <= cmd_op;
        end
    end

    // Latency counter: cleared on accept, counts EXEC cycles until ALU_LAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
        end else if (accept) begin
            lat_cnt <= '0;
        end else if ((state == EXEC) && !lat_done) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
        end
    end

    // Result capture and hold: y/carry taken as-is when the wait expires,
    // kept stable until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y     <= '0;
            res_carry <= 1'b0;
            res_valid <= 1'b0;
        end else if (lat_done) begin
            res_y     <= alu_y;
            res_carry <= alu_carry;
            res_valid <= 1'b1;
        end else if (res_done) begin
            res_valid <= 1'b0;
        end
    end

    // Accumulator and completion counter advance only on a result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            op_count <= '0;
        end else if (res_done) begin
            acc      <= res_y;
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ALU_LAT=0/CNT_W=16 and
// ALU_LAT=3/CNT_W=4) each driving a small combinational ALU model.
// Expected results are pushed when a command is issued; a monitor pops
// and compares on every result handshake.
module tb_alu_op_sequencer;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         cmd_valid   [2];
    logic         cmd_ready   [2];
    logic [W-1:0] cmd_a       [2];
    logic [W-1:0] cmd_b       [2];
    logic [2:0]   cmd_op      [2];
    logic         cmd_use_acc [2];
    logic [W-1:0] alu_a       [2];
    logic [W-1:0] alu_b       [2];
    logic [2:0]   alu_s       [2];
    logic [W-1:0] alu_y       [2];
    logic         alu_carry   [2];
    logic [W:0]   alu_out     [2];
    logic         res_valid   [2];
    logic         res_ready   [2];
    logic [W-1:0] res_y       [2];
    logic         res_carry   [2];
    logic         busy        [2];
    logic [15:0]  op_count0;
    logic [3:0]   op_count1;

    logic [W:0] exp_q0[$];
    logic [W:0] exp_q1[$];
    int checks = 0;
    int errors = 0;
    int hs_edge [2];
    int acc_edge = 0;

    // Bench ALU: 000 add with carry, 001 subtract, 010 and.
    function automatic logic [W:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] s);
        case (s)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a - b};
            3'b010:  return {1'b0, a & b};
            default: return '0;
        endcase
    endfunction

    assign alu_out[0]   = alu_model(alu_a[0], alu_b[0], alu_s[0]);
    assign alu_out[1]   = alu_model(alu_a[1], alu_b[1], alu_s[1]);
    assign alu_y[0]     = alu_out[0][W-1:0];
    assign alu_y[1]     = alu_out[1][W-1:0];
    assign alu_carry[0] = alu_out[0][W];
    assign alu_carry[1] = alu_out[1][W];

    alu_op_sequencer #(.W(W), .ALU_LAT(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]), .cmd_use_acc(cmd_use_acc[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_s(alu_s[0]),
        .alu_y(alu_y[0]), .alu_carry(alu_carry[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_y(res_y[0]), .res_carry(res_carry[0]),
        .busy(busy[0]), .op_count(op_count0)
    );

    alu_op_sequencer #(.W(W), .ALU_LAT(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]), .cmd_use_acc(cmd_use_acc[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_s(alu_s[1]),
        .alu_y(alu_y[1]), .alu_carry(alu_carry[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_y(res_y[1]), .res_carry(res_carry[1]),
        .busy(busy[1]), .op_count(op_count1)
    );

    function automatic logic [31:0] get_cnt(input int d);
        return (d == 0) ? {16'd0, op_count0} : {28'd0, op_count1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per result handshake.
    task automatic monitor();
        logic [W:0] e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n && res_valid[d] && res_ready[d]) begin
                    hs_edge[d] = cyc + 1;
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result dut%0d: got %0d expected none", d,
                                 {res_carry[d], res_y[d]});
                    end else begin
                        if (d == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        check($sformatf("result_dut%0d", d), {23'd0, res_carry[d], res_y[d]},
                              {23'd0, e});
                    end
                end
            end
        end
    endtask

    // Drive one command and wait (bounded) for it to be accepted.
    task automatic send(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic ua, input logic [W:0] exp,
                        input bit push);
        int n = 0;
        @(negedge clk);
        cmd_valid[d]   = 1'b1;
        cmd_a[d]       = a;
        cmd_b[d]       = b;
        cmd_op[d]      = op;
        cmd_use_acc[d] = ua;
        if (push) begin
            if (d == 0) exp_q0.push_back(exp);
            else        exp_q1.push_back(exp);
        end
        while (!cmd_ready[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: got no accept expected accept", d);
            cmd_valid[d] = 1'b0;
            return;
        end
        acc_edge = cyc + 1;
        @(posedge clk);
        #1;
        cmd_valid[d] = 1'b0;
    endtask

    // Wait (bounded) for the result, check latency and the count after the handshake.
    task automatic finish_op(input int d, input int exp_lat, input int exp_cnt);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid[d] && n < 300);
        if (!res_valid[d]) begin
            checks++;
            errors++;
            $display("FAIL result_timeout dut%0d: got no res_valid expected res_valid", d);
            return;
        end
        check($sformatf("latency_dut%0d", d), cyc + 1 - acc_edge, exp_lat);
        @(posedge clk);
        #1;
        check($sformatf("op_count_dut%0d", d), get_cnt(d), exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d]   = 1'b0;
            cmd_a[d]       = '0;
            cmd_b[d]       = '0;
            cmd_op[d]      = '0;
            cmd_use_acc[d] = 1'b0;
            res_ready[d]   = 1'b1;
            hs_edge[d]     = 0;
        end
        #1 rst_n = 1'b0;
        fork
            monitor();
        join_none

        // Reset values.
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_cmd_ready", cmd_ready[d], 1);
            check("rst_busy", busy[d], 0);
            check("rst_res_valid", res_valid[d], 0);
            check("rst_alu_a", alu_a[d], 0);
            check("rst_alu_b", alu_b[d], 0);
            check("rst_alu_s", alu_s[d], 0);
            check("rst_op_count", get_cnt(d), 0);
        end
        rst_n = 1'b1;

        // Basic add: 10+10 = 20, no carry.
        send(0, 8'd10, 8'd10, 3'b000, 1'b0, 9'd20, 1'b1);
        finish_op(0, 2, 1);

        // Chaining: 200+100 = 300 -> y=44 carry=1, then acc-4 = 40.
        send(0, 8'd200, 8'd100, 3'b000, 1'b0, 9'h12C, 1'b1);
        finish_op(0, 2, 2);
        send(0, 8'd0, 8'd4, 3'b001, 1'b1, 9'd40, 1'b1);
        check("chain_alu_a_exec", alu_a[0], 44);
        check("chain_busy", busy[0], 1);
        finish_op(0, 2, 3);
        check("chain_alu_a_held", alu_a[0], 44);
        send(0, 8'hF0, 8'h3C, 3'b010, 1'b0, 9'h030, 1'b1);
        finish_op(0, 2, 4);

        // Backpressure: result held and second command stalled.
        res_ready[0] = 1'b0;
        send(0, 8'd7, 8'd8, 3'b000, 1'b0, 9'd15, 1'b1);
        fork
            send(0, 8'd1, 8'd2, 3'b000, 1'b0, 9'd3, 1'b1);
            begin
                int n = 0;
                while (!res_valid[0] && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 5; k++) begin
                    check("bp_res_valid", res_valid[0], 1);
                    check("bp_cmd_ready", cmd_ready[0], 0);
                    check("bp_res_y", res_y[0], 15);
                    check("bp_alu_a", alu_a[0], 7);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                res_ready[0] = 1'b1;
            end
        join
        check("bp_accept_after_hs", (acc_edge > hs_edge[0]) ? 1 : 0, 1);
        finish_op(0, 2, 6);

        // Reset during EXEC: aborted, nothing produced, counters and acc cleared.
        send(0, 8'd50, 8'd60, 3'b000, 1'b0, 9'd0, 1'b0);
        check("midrst_busy_before", busy[0], 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy[0], 0);
        check("midrst_cmd_ready", cmd_ready[0], 1);
        check("midrst_res_valid", res_valid[0], 0);
        check("midrst_op_count", get_cnt(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'd99, 8'd5, 3'b000, 1'b1, 9'd5, 1'b1);
        check("midrst_acc_zero", alu_a[0], 0);
        finish_op(0, 2, 1);

        // ALU_LAT=3 instance: latency 5 and counter wrap after 16 ops.
        for (int i = 0; i < 16; i++) begin
            send(1, W'(i), 8'd1, 3'b000, 1'b0, 9'(i + 1), 1'b1);
            finish_op(1, 5, (i + 1) % 16);
        end

        repeat (3) @(negedge clk);
        check("queues_drained", exp_q0.size() + exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
